// File: rtl/muldiv_arbiter.sv
// Two-lane round-robin arbiter in front of one shared multiply/divide unit.
// The granted op is latched, issued with a start pulse and its result is returned to the owning lane.
module muldiv_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req0_valid,
    input  logic [7:0]  req0_opcode,
    input  logic [63:0] req0_op1,
    input  logic [63:0] req0_op2,
    input  logic        req1_valid,
    input  logic [7:0]  req1_opcode,
    input  logic [63:0] req1_op1,
    input  logic [63:0] req1_op2,
    output logic        req0_done,
    output logic [63:0] req0_data,
    output logic        req1_done,
    output logic [63:0] req1_data,
    output logic        stall0,
    output logic        stall1,
    output logic        mdu_start,
    output logic        mdu_is_div,
    output logic [7:0]  mdu_opcode,
    output logic [63:0] mdu_op1,
    output logic [63:0] mdu_op2,
    output logic        mdu_kill,
    input  logic        mdu_finish,
    input  logic [63:0] mdu_result
);

    localparam logic [7:0] INST_DIV   = 8'h54;
    localparam logic [7:0] INST_DIVU  = 8'h55;
    localparam logic [7:0] INST_REM   = 8'h56;
    localparam logic [7:0] INST_REMU  = 8'h57;
    localparam logic [7:0] INST_DIVW  = 8'h59;
    localparam logic [7:0] INST_DIVUW = 8'h5A;
    localparam logic [7:0] INST_REMUW = 8'h5B;
    localparam logic [7:0] INST_REMW  = 8'h5C;

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

    state_t      r_state;
    logic        r_ptr;
    logic        r_owner;
    logic        r_is_div;
    logic [7:0]  r_opcode;
    logic [63:0] r_op1;
    logic [63:0] r_op2;
    logic [63:0] r_result;
    logic [63:0] r_data0;
    logic [63:0] r_data1;

    logic        w_grant;
    logic        w_grant_lane;
    logic [7:0]  w_sel_opcode;
    logic [63:0] w_sel_op1;
    logic [63:0] w_sel_op2;
    logic        w_sel_is_div;
    logic        w_done0;
    logic        w_done1;

    // Lane ptr only has priority when both lanes compete.
    always_comb begin
        w_grant      = (r_state == IDLE) & (req0_valid | req1_valid) & ~flush;
        w_grant_lane = (req0_valid & req1_valid) ? r_ptr : req1_valid;
        w_sel_opcode = w_grant_lane ? req1_opcode : req0_opcode;
        w_sel_op1    = w_grant_lane ? req1_op1 : req0_op1;
        w_sel_op2    = w_grant_lane ? req1_op2 : req0_op2;
        case (w_sel_opcode)
            INST_DIV, INST_DIVU, INST_DIVW, INST_DIVUW,
            INST_REM, INST_REMU, INST_REMW, INST_REMUW: w_sel_is_div = 1'b1;
            default:                                    w_sel_is_div = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= 1'b0;
            r_owner  <= 1'b0;
            r_is_div <= 1'b0;
            r_opcode <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_result <= '0;
            r_data0  <= '0;
            r_data1  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner  <= w_grant_lane;
                        r_is_div <= w_sel_is_div;
                        r_opcode <= w_sel_opcode;
                        r_op1    <= w_sel_op1;
                        r_op2    <= w_sel_op2;
                        r_state  <= START;
                    end
                end
                START: begin
                    r_state <= flush ? IDLE : BUSY;
                end
                BUSY: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else if (mdu_finish) begin
                        r_result <= mdu_result;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    // A flushed result is never delivered, so neither the lane data nor the priority moves.
                    if (!flush) begin
                        r_ptr <= ~r_owner;
                        if (r_owner) begin
                            r_data1 <= r_result;
                        end else begin
                            r_data0 <= r_result;
                        end
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_done0 = ~rst & ~flush & (r_state == DONE) & ~r_owner;
    assign w_done1 = ~rst & ~flush & (r_state == DONE) & r_owner;

    // Everything is forced low while reset is held, even before the state register settles.
    assign req0_done  = w_done0;
    assign req1_done  = w_done1;
    assign req0_data  = rst ? '0 : (w_done0 ? r_result : r_data0);
    assign req1_data  = rst ? '0 : (w_done1 ? r_result : r_data1);
    assign stall0     = ~rst & req0_valid & ~w_done0;
    assign stall1     = ~rst & req1_valid & ~w_done1;
    assign mdu_start  = ~rst & ~flush & (r_state == START);
    assign mdu_kill   = ~rst & flush & (r_state != IDLE);
    assign mdu_is_div = ~rst & r_is_div;
    assign mdu_opcode = rst ? '0 : r_opcode;
    assign mdu_op1    = rst ? '0 : r_op1;
    assign mdu_op2    = rst ? '0 : r_op2;

endmodule

// File: doc/muldiv_arbiter.md
MULDIV_ARBITER -- requirements
Module: muldiv_arbiter

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL: flush  input  1  pipeline flush; aborts any operation in flight.
REQ-004 SHALL: reqN_valid (N=0,1)  input  1  issue lane N holds a mul/div/rem op; held high until reqN_done.
REQ-005 SHALL: reqN_opcode  input  8  lane N opcode, using the codebase INST_MUL..INST_REMW encodings.
REQ-006 SHALL: reqN_op1, reqN_op2  input  64  lane N operands, pre-sign/zero-extended for W ops.
REQ-007 SHALL: reqN_done  output  1  one-cycle pulse; reqN_data is valid in this cycle.
REQ-008 SHALL: reqN_data  output  64  result for lane N.
REQ-009 SHALL: stallN  output  1  lane N must hold its pipeline stage.
REQ-010 SHALL: mdu_start  output  1  one-cycle start pulse to the shared multiplier/divider.
REQ-011 SHALL: mdu_is_div  output  1  0 selects the multiplier; 1 selects the divider.
REQ-012 SHALL: mdu_opcode  output  8  latched opcode of the granted op.
REQ-013 SHALL: mdu_op1, mdu_op2  output  64  latched operands of the granted op.
REQ-014 SHALL: mdu_kill  output  1  one-cycle abort pulse to the unit.
REQ-015 SHALL: mdu_finish  input  1  the unit's result is valid this cycle.
REQ-016 SHALL: mdu_result  input  64  the unit's result.

Function
REQ-017 SHALL: FSM states are IDLE, START, BUSY and DONE; the reset state is IDLE.
REQ-018 SHALL: IDLE with any reqN_valid -> grant one lane, latch its opcode/op1/op2 and owner into registers, go to START.
REQ-019 SHALL: arbitration is round-robin with a 1-bit pointer ptr; when both lanes are valid, lane ptr wins; when one lane is valid, it wins regardless of ptr.
REQ-020 SHALL: ptr becomes ~owner on each DONE, so the last-served lane gets the lower priority.
REQ-021 SHALL: in START, mdu_start=1 for exactly one cycle, then the FSM goes to BUSY; mdu_opcode/op1/op2/is_div stay stable from START until leaving DONE.
REQ-022 SHALL: mdu_is_div = 1 for the DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW and REMUW opcodes; otherwise 0.
REQ-023 SHALL: BUSY with mdu_finish=1 -> register mdu_result into a 64-bit result register and go to DONE; mdu_finish in any other state is ignored.
REQ-024 SHALL: in DONE, req[owner]_done=1 and req[owner]_data=the result register for one cycle; the non-owner's done is 0; the FSM then goes to IDLE.
REQ-025 SHALL: reqN_data holds its last value when reqN_done=0.
REQ-026 SHALL: stallN = reqN_valid & ~reqN_done (combinational), so a non-granted lane stalls for the whole time the other lane is served.
REQ-027 SHALL: minimum latency from reqN_valid rising in IDLE to reqN_done is 3 cycles plus the unit latency (IDLE -> START -> BUSY, finish seen, DONE).
REQ-028 SHALL: the cycle after DONE is IDLE, so back-to-back requests lose one cycle; a lane whose valid stays high after its done is treated as a new request.
REQ-029 SHALL: flush=1 in START, BUSY or DONE -> mdu_kill=1 for that cycle, no reqN_done, next state IDLE, ptr unchanged.
REQ-030 SHALL: flush=1 in IDLE -> no grant that cycle and no mdu_kill.
REQ-031 SHALL: a request whose valid drops before DONE without a flush is illegal; the block need not handle it.

Reset
REQ-032 SHALL: rst=1 at a clock edge forces state=IDLE, ptr=0, and clears the result and operand registers.
REQ-033 SHALL: while in reset, all outputs are 0, including mdu_start, mdu_kill, reqN_done and stallN (stall is gated by rst).
REQ-034 SHALL: rst mid-operation drops the op silently, with no done and no kill pulse.

Verification
REQ-035 SHALL: lane0 MUL op1=3 op2=5, unit finishes 4 cycles after start -> mdu_start one pulse, mdu_is_div=0, req0_done pulse with data=15, stall0 high until that cycle.
REQ-036 SHALL: both lanes valid the same cycle after reset (ptr=0), lane0 DIVU 100/7, lane1 REMU 100/7 -> lane0 served first with data=14, then lane1 with data=2; stall1 stays high throughout lane0's service.
REQ-037 SHALL: after REQ-036, both lanes are valid again -> lane0 is granted first (ptr=0 after lane1's DONE).
REQ-038 SHALL: flush asserted in BUSY -> mdu_kill pulse, no done, IDLE next cycle; a later mdu_finish is ignored.
REQ-039 SHALL: rst asserted in BUSY for 1 cycle -> all outputs 0, state IDLE, no done; a new request afterwards completes normally.
REQ-040 SHALL: mdu_finish pulsed while IDLE with no request -> no reqN_done and no state change.
